// File: rtl/rgb_wrd_sched.sv
// rgb_wrd_sched: frame scheduler between rgb_sbit2wrd and the RGB->RGBW converter.
// Buffers 32-bit LED words (bit 31 = end-of-frame) in a FIFO and releases them
// downstream once a start threshold is reached or a whole frame is buffered.
// Optional feature macro: RGB_WRD_SCHED_STATS_EN enables per-frame LED counting
// (out_frame_len / out_frame_done); without it both outputs are tied to 0.
module rgb_wrd_sched #(
  parameter int ADDR_W       = 4,
  parameter int START_THRESH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_word,
  input  logic        in_strobe,
  output logic        out_wr_fifo_full,
  input  logic        in_rd_ready,
  output logic [31:0] out_word,
  output logic        out_valid,
  output logic        out_frame_done,
  output logic [15:0] out_frame_len,
  output logic        out_overflow,
  input  logic        in_clr_overflow
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] THRESH    = (ADDR_W + 1)'(START_THRESH);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [31:0]     mem [DEPTH];
  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic [ADDR_W:0] count;
  logic [ADDR_W:0] count_nxt;
  logic [ADDR_W:0] eof_cnt;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            push_eof;
  logic            pop_eof;
  logic [31:0]     head;

  assign count     = wr_ptr - rd_ptr;
  assign full      = (count == DEPTH_CNT);
  assign empty     = (count == '0);
  assign head      = mem[rd_ptr[ADDR_W-1:0]];
  assign push      = in_strobe && !full;
  assign pop       = out_valid && in_rd_ready;
  assign push_eof  = push && in_word[31];
  assign pop_eof   = pop && head[31];
  assign count_nxt = count + {{ADDR_W{1'b0}}, push} - {{ADDR_W{1'b0}}, pop};

  assign out_wr_fifo_full = full;
  assign out_valid        = (state == DRAIN) && !empty;
  assign out_word         = empty ? '0 : head;

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[ADDR_W-1:0]] <= in_word;
  end

  // Read/write pointers, one extra bit so full and empty are distinguishable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Number of end-of-frame words currently held in the FIFO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      eof_cnt <= '0;
    end else begin
      case ({push_eof, pop_eof})
        2'b10:   eof_cnt <= eof_cnt + 1'b1;
        2'b01:   eof_cnt <= eof_cnt - 1'b1;
        default: eof_cnt <= eof_cnt;
      endcase
    end
  end

  // Scheduler state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state: start draining at threshold or with a complete frame buffered;
  // after each frame, re-evaluate from FILL (or idle out if nothing remains).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (push) state_nxt = FILL;
      FILL:    if ((count >= THRESH) || (eof_cnt != '0)) state_nxt = DRAIN;
      DRAIN:   if (pop_eof) state_nxt = (count_nxt == '0) ? IDLE : FILL;
      default: state_nxt = IDLE;
    endcase
  end

  // Sticky overflow on a dropped write; a drop in the same cycle beats a clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   out_overflow <= 1'b0;
    else if (in_strobe && full) out_overflow <= 1'b1;
    else if (in_clr_overflow)   out_overflow <= 1'b0;
  end

`ifdef RGB_WRD_SCHED_STATS_EN
  logic [15:0] flen;

  // Per-frame LED counter; the EOF word closes the frame and is not counted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flen           <= '0;
      out_frame_len  <= '0;
      out_frame_done <= 1'b0;
    end else begin
      out_frame_done <= 1'b0;
      if (pop_eof) begin
        out_frame_len  <= flen;
        flen           <= '0;
        out_frame_done <= 1'b1;
      end else if (pop && (flen != 16'hFFFF)) begin
        flen <= flen + 16'd1;
      end
    end
  end
`else
  assign out_frame_len  = '0;
  assign out_frame_done = 1'b0;
`endif

endmodule
